// File: rtl/vga_scanout.sv
// VGA scan-out engine: 640x480@60 timing, pixel-doubled 320x240 RGB565 frame-buffer reads,
// RGB444 + active-low syncs on the pins with a fixed two-tick pipeline.
module vga_scanout #(
    parameter int          CLK_DIV   = 4,
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          FB_WIDTH  = 320,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ram_ena,
    output logic        ram_wena,
    output logic [31:0] ram_addr,
    input  logic [15:0] ram_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        vblank,
    output logic        frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt_r;
    logic          tick_s;
    logic [HW-1:0] h_cnt_r;
    logic [HW-1:0] h_next_s;
    logic [VW-1:0] v_cnt_r;
    logic [VW-1:0] v_next_s;
    logic          active0_s;
    logic          hs0_s;
    logic          vs0_s;
    logic          last_pix_s;
    logic [31:0]   addr0_s;
    logic          de1_r;
    logic          hs1_r;
    logic          vs1_r;
    logic          unused_data_s;

    assign tick_s        = (div_cnt_r == DIV_LAST);
    assign ram_wena      = 1'b0;
    assign unused_data_s = ^{ram_data[11], ram_data[6:5], ram_data[0]};

    // Next raster position and stage-0 decode of the current position.
    always_comb begin
        h_next_s   = h_cnt_r;
        v_next_s   = v_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_next_s = {HW{1'b0}};
            if (v_cnt_r == V_LAST) begin
                v_next_s = {VW{1'b0}};
            end else begin
                v_next_s = v_cnt_r + 1'b1;
            end
        end else begin
            h_next_s = h_cnt_r + 1'b1;
        end
        active0_s  = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
        hs0_s      = !((h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
        vs0_s      = !((v_cnt_r >= VS_START) && (v_cnt_r < VS_END));
        last_pix_s = (h_cnt_r == H_ACT_END) && (v_cnt_r == V_ACT_END);
        // Halving both coordinates doubles each frame-buffer pixel in x and y.
        addr0_s    = BASE_ADDR + (32'(v_cnt_r >> 1) * 32'(FB_WIDTH)) + 32'(h_cnt_r >> 1);
    end

    // Pixel-tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {DW{1'b0}};
        end else if (tick_s) begin
            div_cnt_r <= {DW{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
        end
    end

    // Stage 0: raster counters plus the vblank view of the row counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
            vblank  <= 1'b0;
        end else if (tick_s) begin
            h_cnt_r <= h_next_s;
            v_cnt_r <= v_next_s;
            vblank  <= (v_next_s >= V_ACT);
        end
    end

    // Stage 1: RAM address issue; address holds through blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ena    <= 1'b0;
            ram_addr   <= BASE_ADDR;
            de1_r      <= 1'b0;
            hs1_r      <= 1'b1;
            vs1_r      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick_s && last_pix_s;
            if (tick_s) begin
                ram_ena <= active0_s;
                de1_r   <= active0_s;
                hs1_r   <= hs0_s;
                vs1_r   <= vs0_s;
                if (active0_s) begin
                    ram_addr <= addr0_s;
                end
            end
        end
    end

    // Stage 2: pin registers; RAM data is only sampled while the read was enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r  <= 4'h0;
            vga_g  <= 4'h0;
            vga_b  <= 4'h0;
            vga_de <= 1'b0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else if (tick_s) begin
            vga_r  <= ram_ena ? ram_data[15:12] : 4'h0;
            vga_g  <= ram_ena ? ram_data[10:7]  : 4'h0;
            vga_b  <= ram_ena ? ram_data[4:1]   : 4'h0;
            vga_de <= de1_r;
            vga_hs <= hs1_r;
            vga_vs <= vs1_r;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance for line timing and address walk, and a
// shrunken-raster instance so whole frames (vsync, vblank, frame_done) fit a short run.
module tb_vga_scanout;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ram_ena_a, ram_wena_a, vga_hs_a, vga_vs_a, vga_de_a, vblank_a, frame_done_a;
    logic [31:0] ram_addr_a;
    logic [15:0] ram_data_a;
    logic [3:0]  vga_r_a, vga_g_a, vga_b_a;
    logic        ram_ena_b, ram_wena_b, vga_hs_b, vga_vs_b, vga_de_b, vblank_b, frame_done_b;
    logic [31:0] ram_addr_b;
    logic [15:0] ram_data_b;
    logic [3:0]  vga_r_b, vga_g_b, vga_b_b;

    function automatic logic [15:0] ram_a_word(input logic [31:0] a);
        case (a)
            32'd0:   return 16'hF800;
            32'd1:   return 16'h07E0;
            32'd2:   return 16'h001F;
            32'd320: return 16'hA5C3;
            default: return 16'hFFFF;
        endcase
    endfunction

    assign ram_data_a = ram_ena_a ? ram_a_word(ram_addr_a) : 16'hzzzz;
    assign ram_data_b = ram_ena_b ? 16'hFFFF : 16'hzzzz;

    vga_scanout dut_a (
        .clk(clk), .rst_n(rst_n), .ram_ena(ram_ena_a), .ram_wena(ram_wena_a),
        .ram_addr(ram_addr_a), .ram_data(ram_data_a), .vga_r(vga_r_a), .vga_g(vga_g_a),
        .vga_b(vga_b_a), .vga_hs(vga_hs_a), .vga_vs(vga_vs_a), .vga_de(vga_de_a),
        .vblank(vblank_a), .frame_done(frame_done_a)
    );

    // 16x10 raster, 8x6 active, hsync h 10..12, vsync v 7..8, CLK_DIV 2, base 1000.
    vga_scanout #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .FB_WIDTH(4), .BASE_ADDR(32'd1000)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ram_ena(ram_ena_b), .ram_wena(ram_wena_b),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b), .vga_r(vga_r_b), .vga_g(vga_g_b),
        .vga_b(vga_b_b), .vga_hs(vga_hs_b), .vga_vs(vga_vs_b), .vga_de(vga_de_b),
        .vblank(vblank_b), .frame_done(frame_done_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc;
    logic wena_bad = 1'b0;

    // Clock edges since reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (ram_wena_a !== 1'b0 || ram_wena_b !== 1'b0) wena_bad <= 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ena_a"}, ram_ena_a, 1'b0);
        chk({tag, "_addr_a"}, ram_addr_a, 32'd0);
        chk({tag, "_rgb_a"}, {vga_r_a, vga_g_a, vga_b_a}, 12'h000);
        chk({tag, "_de_hs_vs_a"}, {vga_de_a, vga_hs_a, vga_vs_a}, 3'b011);
        chk({tag, "_vb_fd_a"}, {vblank_a, frame_done_a}, 2'b00);
        chk({tag, "_ena_b"}, ram_ena_b, 1'b0);
        chk({tag, "_addr_b"}, ram_addr_b, 32'd1000);
        chk({tag, "_rgb_b"}, {vga_r_b, vga_g_b, vga_b_b}, 12'h000);
        chk({tag, "_de_hs_vs_b"}, {vga_de_b, vga_hs_b, vga_vs_b}, 3'b011);
        chk({tag, "_vb_fd_b"}, {vblank_b, frame_done_b}, 2'b00);
    endtask

    // Waits for vga_hs_a to reach lvl, counting display-enable samples on the way.
    task automatic wait_hs(input logic lvl, output int c, output int de_n, output bit ok);
        int n = 0;
        de_n = 0;
        while (vga_hs_a !== lvl && n < 10000) begin
            @(negedge clk);
            n++;
            de_n += int'(vga_de_a);
        end
        ok = (vga_hs_a === lvl);
        c  = cyc;
    endtask

    typedef struct {
        int          h;
        int          v;
        logic [31:0] addr;
        logic        ena;
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{0,   0,  32'd0,    1'b1, 1'b1, 1'b1, 1'b1, 12'hF00};
        tbl[1]  = '{1,   0,  32'd0,    1'b1, 1'b1, 1'b1, 1'b1, 12'hF00};
        tbl[2]  = '{2,   0,  32'd1,    1'b1, 1'b1, 1'b1, 1'b1, 12'h0F0};
        tbl[3]  = '{4,   0,  32'd2,    1'b1, 1'b1, 1'b1, 1'b1, 12'h00F};
        tbl[4]  = '{639, 0,  32'd319,  1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF};
        tbl[5]  = '{640, 0,  32'd319,  1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[6]  = '{655, 0,  32'd319,  1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[7]  = '{656, 0,  32'd319,  1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[8]  = '{751, 0,  32'd319,  1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[9]  = '{752, 0,  32'd319,  1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[10] = '{799, 0,  32'd319,  1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[11] = '{0,   1,  32'd0,    1'b1, 1'b1, 1'b1, 1'b1, 12'hF00};
        tbl[12] = '{0,   2,  32'd320,  1'b1, 1'b1, 1'b1, 1'b1, 12'hAB1};
        tbl[13] = '{2,   2,  32'd321,  1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF};
        tbl[14] = '{639, 3,  32'd639,  1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF};
        tbl[15] = '{0,   11, 32'd1600, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF};

        repeat (10) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        fork
            begin : seq_a
                int t0, t1, t2, d0, d1, d2;
                bit ok0, ok1, ok2;
                for (int i = 0; i < 16; i++) begin
                    int p;
                    p = tbl[i].v * 800 + tbl[i].h;
                    wait_cyc(4 * (p + 1));
                    chk($sformatf("addr_%0d_%0d", tbl[i].h, tbl[i].v), ram_addr_a, tbl[i].addr);
                    chk($sformatf("ena_%0d_%0d", tbl[i].h, tbl[i].v), ram_ena_a, tbl[i].ena);
                    wait_cyc(4 * (p + 2));
                    chk($sformatf("de_hs_vs_%0d_%0d", tbl[i].h, tbl[i].v),
                        {vga_de_a, vga_hs_a, vga_vs_a}, {tbl[i].de, tbl[i].hs, tbl[i].vs});
                    chk($sformatf("rgb_%0d_%0d", tbl[i].h, tbl[i].v),
                        {vga_r_a, vga_g_a, vga_b_a}, tbl[i].rgb);
                end
                wait_hs(1'b0, t0, d0, ok0);
                wait_hs(1'b1, t1, d1, ok1);
                wait_hs(1'b0, t2, d2, ok2);
                chk("hs_edges_seen", {ok0, ok1, ok2}, 3'b111);
                chk("hs_low_clk", t1 - t0, 384);
                chk("hs_period_clk", t2 - t0, 3200);
                chk("de_clk_per_line", d1 + d2, 2560);
            end
            begin : seq_b
                int fd_n, de_n, vs_fall;
                logic prev_vs;
                wait_cyc(2);
                chk("b_first_addr", {ram_ena_b, ram_addr_b}, {1'b1, 32'd1000});
                wait_cyc(18);
                chk("b_blank_addr", {ram_ena_b, ram_addr_b}, {1'b0, 32'd1003});
                chk("b_last_px_rgb", {vga_de_b, vga_r_b, vga_g_b, vga_b_b}, {1'b1, 12'hFFF});
                wait_cyc(20);
                chk("b_blank_rgb", {vga_de_b, vga_r_b, vga_g_b, vga_b_b}, {1'b0, 12'h000});
                wait_cyc(22);
                chk("b_hs_pre", vga_hs_b, 1'b1);
                wait_cyc(24);
                chk("b_hs_low", vga_hs_b, 1'b0);
                wait_cyc(175);
                chk("b_fd_pre", frame_done_b, 1'b0);
                wait_cyc(176);
                chk("b_fd_pulse", {frame_done_b, ram_addr_b}, {1'b1, 32'd1011});
                wait_cyc(177);
                chk("b_fd_post", frame_done_b, 1'b0);
                wait_cyc(191);
                chk("b_vblank_pre", vblank_b, 1'b0);
                wait_cyc(192);
                chk("b_vblank_rise", vblank_b, 1'b1);
                wait_cyc(227);
                chk("b_vs_pre", vga_vs_b, 1'b1);
                wait_cyc(228);
                chk("b_vs_fall", vga_vs_b, 1'b0);
                wait_cyc(291);
                chk("b_vs_end", vga_vs_b, 1'b0);
                wait_cyc(292);
                chk("b_vs_rise", vga_vs_b, 1'b1);
                wait_cyc(319);
                chk("b_vblank_hold", vblank_b, 1'b1);
                wait_cyc(320);
                chk("b_vblank_fall", vblank_b, 1'b0);
                fd_n = 0; de_n = 0; vs_fall = -1; prev_vs = vga_vs_b;
                for (int k = 321; k <= 640; k++) begin
                    wait_cyc(k);
                    fd_n += int'(frame_done_b);
                    de_n += int'(vga_de_b);
                    if (prev_vs === 1'b1 && vga_vs_b === 1'b0) vs_fall = k;
                    prev_vs = vga_vs_b;
                end
                chk("b_fd_per_frame", fd_n, 1);
                chk("b_de_clk_per_frame", de_n, 96);
                chk("b_vs_period", vs_fall, 548);
            end
        join

        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(7600);
        chk("mid_pre_de_a", {ram_ena_a, vga_de_a}, 2'b11);
        chk("mid_pre_addr_a", ram_addr_a, 32'd469);
        chk("mid_pre_vs_b", vga_vs_b, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(4);
        chk("restart_addr_a", {ram_ena_a, ram_addr_a}, {1'b1, 32'd0});
        wait_cyc(8);
        chk("restart_pins_a", {vga_de_a, vga_hs_a, vga_r_a, vga_g_a, vga_b_a}, {2'b11, 12'hF00});
        chk("ram_wena_never", wena_bad, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
